// File: rtl/oam_dma_controller_if.sv
// Bus bundle between the CPU-side DMA controller and its neighbours:
// launch parameters, main-memory read port, and sprite-RAM port A.
interface oam_dma_controller_if #(
    parameter int SRC_W  = 16,
    parameter int OAM_W  = 10,
    parameter int DATA_W = 16
);
    logic              start;
    logic [SRC_W-1:0]  src_base;
    logic [OAM_W-1:0]  dst_base;
    logic [OAM_W:0]    word_count;
    logic              vblank;

    logic              mem_req;
    logic [SRC_W-1:0]  mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    logic              cpu_en;
    logic              cpu_we;
    logic [OAM_W-1:0]  cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;

    logic              oam_en;
    logic              oam_we;
    logic [OAM_W-1:0]  oam_addr;
    logic [DATA_W-1:0] oam_wdata;

    logic              busy;
    logic              done;

    modport master (
        output start, src_base, dst_base, word_count, vblank,
        output mem_ack, mem_rdata,
        output cpu_en, cpu_we, cpu_addr, cpu_wdata,
        input  mem_req, mem_addr,
        input  oam_en, oam_we, oam_addr, oam_wdata,
        input  busy, done
    );

    modport slave (
        input  start, src_base, dst_base, word_count, vblank,
        input  mem_ack, mem_rdata,
        input  cpu_en, cpu_we, cpu_addr, cpu_wdata,
        output mem_req, mem_addr,
        output oam_en, oam_we, oam_addr, oam_wdata,
        output busy, done
    );
endinterface

// File: rtl/oam_dma_controller.sv
// Copies a block of main memory into sprite RAM during vertical blank,
// yielding sprite-RAM port A to the CPU whenever it asks for it.
module oam_dma_controller #(
    parameter int SRC_W  = 16,
    parameter int OAM_W  = 10,
    parameter int DATA_W = 16
) (
    input logic                 clk,
    input logic                 rst,
    oam_dma_controller_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        WAIT_VB,
        FETCH,
        WRITE,
        DONE
    } state_t;

    localparam logic [OAM_W:0] REMAIN_ONE = {{OAM_W{1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [SRC_W-1:0]  src_ptr_q, src_ptr_d;
    logic [OAM_W-1:0]  dst_ptr_q, dst_ptr_d;
    logic [OAM_W:0]    remain_q, remain_d;
    logic [DATA_W-1:0] data_reg_q, data_reg_d;
    logic              mem_req_q, mem_req_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_comb begin
        state_d    = state_q;
        src_ptr_d  = src_ptr_q;
        dst_ptr_d  = dst_ptr_q;
        remain_d   = remain_q;
        data_reg_d = data_reg_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    src_ptr_d = bus.src_base;
                    dst_ptr_d = bus.dst_base;
                    remain_d  = bus.word_count;
                    state_d   = (bus.word_count == '0) ? DONE : WAIT_VB;
                end
            end
            WAIT_VB: begin
                if (bus.vblank) state_d = FETCH;
            end
            FETCH: begin
                if (bus.mem_ack) begin
                    data_reg_d = bus.mem_rdata;
                    src_ptr_d  = src_ptr_q + SRC_W'(1);
                    state_d    = WRITE;
                end
            end
            WRITE: begin
                // a CPU access defers the write; data_reg is simply held
                if (!bus.cpu_en) begin
                    dst_ptr_d = dst_ptr_q + OAM_W'(1);
                    remain_d  = remain_q - REMAIN_ONE;
                    if (remain_q == REMAIN_ONE) state_d = DONE;
                    else if (bus.vblank)        state_d = FETCH;
                    else                        state_d = WAIT_VB;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        mem_req_d = (state_d == FETCH);
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            src_ptr_q  <= '0;
            dst_ptr_q  <= '0;
            remain_q   <= '0;
            data_reg_q <= '0;
            mem_req_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_ptr_q  <= src_ptr_d;
            dst_ptr_q  <= dst_ptr_d;
            remain_q   <= remain_d;
            data_reg_q <= data_reg_d;
            mem_req_q  <= mem_req_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    logic              oam_en, oam_we;
    logic [OAM_W-1:0]  oam_addr;
    logic [DATA_W-1:0] oam_wdata;

    // CPU owns the port in any state, even while the DMA is held in reset
    always_comb begin
        oam_en    = 1'b0;
        oam_we    = 1'b0;
        oam_addr  = '0;
        oam_wdata = '0;
        if (bus.cpu_en) begin
            oam_en    = 1'b1;
            oam_we    = bus.cpu_we;
            oam_addr  = bus.cpu_addr;
            oam_wdata = bus.cpu_wdata;
        end else if (state_q == WRITE) begin
            oam_en    = 1'b1;
            oam_we    = 1'b1;
            oam_addr  = dst_ptr_q;
            oam_wdata = data_reg_q;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_addr  = src_ptr_q;
    assign bus.oam_en    = oam_en;
    assign bus.oam_we    = oam_we;
    assign bus.oam_addr  = oam_addr;
    assign bus.oam_wdata = oam_wdata;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_oam_dma_controller.sv
// Bench for oam_dma_controller: vector table, corner-case sequences and
// randomized transfers checked against an address-list reference model.
module tb_oam_dma_controller;
    localparam int SRC_W  = 16;
    localparam int OAM_W  = 10;
    localparam int DATA_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    oam_dma_controller_if #(
        .SRC_W(SRC_W), .OAM_W(OAM_W), .DATA_W(DATA_W)
    ) bus ();

    oam_dma_controller #(
        .SRC_W(SRC_W), .OAM_W(OAM_W), .DATA_W(DATA_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct {
        logic [OAM_W-1:0]  addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    typedef struct {
        logic [SRC_W-1:0]  src;
        logic [OAM_W-1:0]  dst;
        int                cnt;
        int                lat;
        bit                restart;
        logic [OAM_W-1:0]  last_a;
        logic [DATA_W-1:0] last_d;
    } vec_t;

    wr_t               exp_q[$];
    int                n_cmp = 0;
    int                n_bad = 0;
    int                lat = 1;
    int                ack_cnt = 0;
    int                writes_seen = 0;
    int                done_seen = 0;
    int                cyc = 0;
    int                start_cyc = 0;
    int                done_cyc = 0;
    logic [OAM_W-1:0]  last_addr = '0;
    logic [DATA_W-1:0] last_data = '0;

    function automatic logic [DATA_W-1:0] mem_val(logic [SRC_W-1:0] a);
        return a ^ 16'hA5A5;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // reference: the n-th word lands at dst+n and holds mem[src+n]
    task automatic plan(logic [SRC_W-1:0] src, logic [OAM_W-1:0] dst, int cnt);
        for (int i = 0; i < cnt; i++) begin
            wr_t w;
            w.addr = OAM_W'(int'(dst) + i);
            w.data = mem_val(SRC_W'(int'(src) + i));
            exp_q.push_back(w);
        end
    endtask

    task automatic monitor();
        cyc++;
        if (bus.start === 1'b1 && bus.busy === 1'b0) start_cyc = cyc;
        if (bus.done === 1'b1) begin
            done_seen++;
            done_cyc = cyc;
        end
        if (bus.cpu_en) begin
            chk("cpu_pass",
                32'({bus.oam_en, bus.oam_we, bus.oam_addr, bus.oam_wdata}),
                32'({1'b1, bus.cpu_we, bus.cpu_addr, bus.cpu_wdata}));
        end else if (bus.oam_en === 1'b1) begin
            writes_seen++;
            last_addr = bus.oam_addr;
            last_data = bus.oam_wdata;
            chk("wr_expected", 32'(exp_q.size() != 0), 32'(1));
            chk("wr_we", 32'(bus.oam_we), 32'(1));
            if (exp_q.size() != 0) begin
                wr_t w;
                w = exp_q.pop_front();
                chk("wr_addr", 32'(bus.oam_addr), 32'(w.addr));
                chk("wr_data", 32'(bus.oam_wdata), 32'(w.data));
            end
        end else begin
            chk("oam_idle",
                32'({bus.oam_en, bus.oam_we, bus.oam_addr, bus.oam_wdata}),
                32'(0));
        end
    endtask

    // one clock: observe the cycle, clock it, then answer the memory port
    task automatic step();
        #1;
        monitor();
        @(posedge clk);
        #1;
        if (!bus.mem_req || bus.mem_ack) begin
            bus.mem_ack = 1'b0;
            ack_cnt = 0;
        end else if (ack_cnt >= lat) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = mem_val(bus.mem_addr);
        end else begin
            ack_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic pulse_start(logic [SRC_W-1:0] src, logic [OAM_W-1:0] dst,
                               int cnt);
        bus.src_base   = src;
        bus.dst_base   = dst;
        bus.word_count = (OAM_W + 1)'(cnt);
        bus.start      = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(int budget);
        int d0 = done_seen;
        for (int i = 0; i < budget && done_seen == d0; i++) step();
        chk("done_in_time", 32'(done_seen != d0), 32'(1));
    endtask

    task automatic run_dma(vec_t v);
        int d0 = done_seen;
        int w0 = writes_seen;
        int budget = v.cnt * (v.lat + 2) * 2 + 50;
        lat = v.lat;
        plan(v.src, v.dst, v.cnt);
        pulse_start(v.src, v.dst, v.cnt);
        for (int i = 0; i < budget && done_seen == d0; i++) begin
            if (v.restart && i == 3) begin
                pulse_start(16'h7777, 10'h155, 5);
            end else begin
                step();
            end
        end
        chk("cycles", 32'(done_cyc - start_cyc), 32'(2 + v.cnt * (v.lat + 2)));
        step();
        step();
        chk("done_once", 32'(done_seen - d0), 32'(1));
        chk("n_writes", 32'(writes_seen - w0), 32'(v.cnt));
        chk("q_empty", 32'(exp_q.size()), 32'(0));
        chk("busy_end", 32'(bus.busy), 32'(0));
        chk("last_addr", 32'(last_addr), 32'(v.last_a));
        chk("last_data", 32'(last_data), 32'(v.last_d));
        exp_q.delete();
    endtask

    vec_t vt[5];

    initial begin
        int d0;
        int w0;
        int bad_req;
        int bad_busy;

        vt[0] = '{16'h4000, 10'h000, 4,    1, 1'b0, 10'h003, 16'hE5A6};
        vt[1] = '{16'h0000, 10'h3FE, 4,    0, 1'b1, 10'h001, 16'hA5A6};
        vt[2] = '{16'hFFFE, 10'h100, 3,    2, 1'b0, 10'h102, 16'hA5A5};
        vt[3] = '{16'h1234, 10'h010, 1,    3, 1'b0, 10'h010, 16'hB791};
        vt[4] = '{16'h0100, 10'h200, 1024, 0, 1'b1, 10'h1FF, 16'hA15A};

        bus.start      = 1'b0;
        bus.src_base   = '0;
        bus.dst_base   = '0;
        bus.word_count = '0;
        bus.vblank     = 1'b0;
        bus.mem_ack    = 1'b0;
        bus.mem_rdata  = '0;
        bus.cpu_en     = 1'b1;
        bus.cpu_we     = 1'b1;
        bus.cpu_addr   = 10'h2AA;
        bus.cpu_wdata  = 16'h1234;

        // reset state, with the CPU path live during reset
        step();
        chk("rst_mem_req", 32'(bus.mem_req), 32'(0));
        chk("rst_busy", 32'(bus.busy), 32'(0));
        chk("rst_done", 32'(bus.done), 32'(0));
        bus.cpu_en = 1'b0;
        step();
        rst = 1'b1;
        step();

        bus.vblank = 1'b1;
        for (int i = 0; i < 5; i++) run_dma(vt[i]);

        // zero count
        d0 = done_seen;
        pulse_start(16'h8000, 10'h000, 0);
        chk("zc_done", 32'(bus.done), 32'(1));
        chk("zc_busy", 32'(bus.busy), 32'(1));
        chk("zc_req", 32'(bus.mem_req), 32'(0));
        step();
        chk("zc_done_low", 32'(bus.done), 32'(0));
        chk("zc_busy_low", 32'(bus.busy), 32'(0));
        step();
        chk("zc_done_once", 32'(done_seen - d0), 32'(1));

        // vblank gating, pause after word 2 and resume at word 3
        bus.vblank = 1'b0;
        lat = 1;
        w0 = writes_seen;
        plan(16'h2000, 10'h040, 8);
        pulse_start(16'h2000, 10'h040, 8);
        bad_req = 0;
        bad_busy = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (bus.mem_req !== 1'b0) bad_req++;
            if (bus.busy !== 1'b1) bad_busy++;
        end
        chk("vb_no_req", 32'(bad_req), 32'(0));
        chk("vb_busy", 32'(bad_busy), 32'(0));
        bus.vblank = 1'b1;
        step();
        chk("vb_req_next", 32'(bus.mem_req), 32'(1));
        for (int i = 0; i < 40 && writes_seen - w0 < 2; i++) step();
        bus.vblank = 1'b0;
        for (int i = 0; i < 40 && writes_seen - w0 < 3; i++) step();
        bad_req = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.mem_req !== 1'b0) bad_req++;
        end
        chk("vb_paused_req", 32'(bad_req), 32'(0));
        chk("vb_paused_wr", 32'(writes_seen - w0), 32'(3));
        bus.vblank = 1'b1;
        wait_done(200);
        step();
        chk("vb_n_writes", 32'(writes_seen - w0), 32'(8));
        chk("vb_q_empty", 32'(exp_q.size()), 32'(0));
        exp_q.delete();

        // CPU conflict while a word waits in WRITE
        lat = 1;
        w0 = writes_seen;
        plan(16'h5000, 10'h080, 2);
        pulse_start(16'h5000, 10'h080, 2);
        for (int i = 0; i < 20 && bus.mem_ack !== 1'b1; i++) step();
        bus.cpu_en    = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 10'h3FF;
        bus.cpu_wdata = 16'hBEEF;
        step();
        for (int i = 0; i < 3; i++) step();
        chk("cpu_deferred", 32'(writes_seen - w0), 32'(0));
        chk("cpu_busy", 32'(bus.busy), 32'(1));
        bus.cpu_en = 1'b0;
        step();
        chk("cpu_commit", 32'(writes_seen - w0), 32'(1));
        chk("cpu_commit_a", 32'(last_addr), 32'(10'h080));
        chk("cpu_commit_d", 32'(last_data), 32'(16'hF5A5));
        wait_done(50);
        step();
        chk("cpu_q_empty", 32'(exp_q.size()), 32'(0));
        exp_q.delete();

        // reset in FETCH abandons the transfer
        lat = 3;
        d0 = done_seen;
        w0 = writes_seen;
        pulse_start(16'h3000, 10'h000, 4);
        for (int i = 0; i < 10 && bus.mem_req !== 1'b1; i++) step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("mid_rst_req", 32'(bus.mem_req), 32'(0));
        chk("mid_rst_busy", 32'(bus.busy), 32'(0));
        for (int i = 0; i < 10; i++) step();
        chk("mid_rst_no_done", 32'(done_seen - d0), 32'(0));
        chk("mid_rst_no_wr", 32'(writes_seen - w0), 32'(0));
        run_dma('{16'h3000, 10'h000, 4, 3, 1'b0, 10'h003, 16'h95A6});

        // randomized transfers under random vblank and CPU traffic
        for (int t = 0; t < 8; t++) begin
            logic [SRC_W-1:0] src;
            logic [OAM_W-1:0] dst;
            int cnt;
            src = SRC_W'($urandom);
            dst = OAM_W'($urandom);
            cnt = int'($urandom_range(1, 40));
            lat = int'($urandom_range(0, 3));
            d0 = done_seen;
            w0 = writes_seen;
            plan(src, dst, cnt);
            pulse_start(src, dst, cnt);
            for (int i = 0; i < 3000 && done_seen == d0; i++) begin
                bus.vblank    = ($urandom_range(0, 3) != 0);
                bus.cpu_en    = ($urandom_range(0, 3) == 0);
                bus.cpu_we    = 1'($urandom);
                bus.cpu_addr  = OAM_W'($urandom);
                bus.cpu_wdata = DATA_W'($urandom);
                step();
            end
            bus.cpu_en = 1'b0;
            bus.vblank = 1'b1;
            step();
            step();
            chk("rnd_done_once", 32'(done_seen - d0), 32'(1));
            chk("rnd_n_writes", 32'(writes_seen - w0), 32'(cnt));
            chk("rnd_q_empty", 32'(exp_q.size()), 32'(0));
            chk("rnd_busy_end", 32'(bus.busy), 32'(0));
            exp_q.delete();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
